// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one WIDTH-bit flip-flop bank.
// Each completed write is followed by HOLD idle cycles before the next arbitration.
module dff_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HOLD  = 2,
    localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [OW-1:0]         owner,
    output logic [WIDTH-1:0]      q0,
    output logic [WIDTH-1:0]      q1,
    output logic [15:0]           wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_HOLD
    } state_t;

    state_t           r_state, w_state_nx;
    logic [NREQ-1:0]  r_gnt, w_gnt_nx;
    logic [OW-1:0]    r_owner, w_owner_nx;
    logic [OW-1:0]    r_last, w_last_nx;
    logic [WIDTH-1:0] r_q, w_q_nx;
    logic [15:0]      r_cnt, w_cnt_nx;
    logic [3:0]       r_hold, w_hold_nx;

    logic             w_found;
    logic [OW-1:0]    w_win;
    logic [OW-1:0]    w_idx;

    // Rotating search starting one past the most recently written requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = OW'((32'(r_last) + 32'd1 + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = '0;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_q_nx     = r_q;
        w_cnt_nx   = r_cnt;
        w_hold_nx  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx = S_GRANT;
                    w_owner_nx = w_win;
                    w_gnt_nx   = NREQ'(1) << w_win;
                end
            end
            S_GRANT: begin
                if (req[r_owner]) begin
                    w_q_nx    = wdata[r_owner*WIDTH +: WIDTH];
                    w_cnt_nx  = r_cnt + 16'd1;
                    w_last_nx = r_owner;
                    if (HOLD == 0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_HOLD;
                        w_hold_nx  = 4'(HOLD - 1);
                    end
                end else begin
                    // Withdrawn request: drop the write, leave the pointer alone.
                    w_state_nx = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_hold == 4'd0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_hold_nx = r_hold - 4'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= OW'(NREQ - 1);
            r_q     <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_q     <= w_q_nx;
            r_cnt   <= w_cnt_nx;
            r_hold  <= w_hold_nx;
        end
    end

    assign gnt      = r_gnt;
    assign busy     = (r_state != S_IDLE);
    assign owner    = r_owner;
    assign q0       = r_q;
    assign q1       = ~r_q;
    assign wr_count = r_cnt;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, WIDTH=8, HOLD=2) with per-cycle
// invariant checks on the negative clock edge.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  q0;
    logic [7:0]  q1;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    dff_bank_arbiter #(
        .NREQ (4),
        .WIDTH(8),
        .HOLD (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .busy    (busy),
        .owner   (owner),
        .q0      (q0),
        .q1      (q1),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            assert (q1 === ~q0)
            else begin
                errors++;
                $error("FAIL prop_q1_compl: observed=%h expected=%h", q1, ~q0);
            end
            checks++;
            assert ($onehot0(gnt))
            else begin
                errors++;
                $error("FAIL prop_gnt_onehot0: observed=%b expected=onehot0", gnt);
            end
            checks++;
            assert (gnt == 4'b0000 || busy)
            else begin
                errors++;
                $error("FAIL prop_gnt_busy: observed busy=%b gnt=%b expected busy=1", busy, gnt);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;

        // Reset held two cycles
        step();
        step();
        armed = 1'b1;
        check("rst_q0", 32'(q0), 32'h00);
        check("rst_q1", 32'(q1), 32'hFF);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_cnt", 32'(wr_count), 32'h0);
        reset = 1'b0;

        // Abort: requester 1 wins, drops request during GRANT
        req   = 4'b0010;
        wdata = 32'h0000_EE00;
        step();
        check("abort_gnt", 32'(gnt), 32'b0010);
        check("abort_owner", 32'(owner), 32'd1);
        req = 4'b0000;
        step();
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_q0", 32'(q0), 32'h00);
        check("abort_cnt", 32'(wr_count), 32'h0);
        step();
        req   = 4'b0011;
        wdata = 32'h0000_EE11;
        step();
        check("abort_next_gnt", 32'(gnt), 32'b0001);
        check("abort_next_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        step();
        check("abort2_q0", 32'(q0), 32'h00);
        check("abort2_cnt", 32'(wr_count), 32'h0);

        // Single write from requester 2, non-owner slice changes mid-grant
        req   = 4'b0100;
        wdata = 32'h77A5_3322;
        step();
        check("wr_gnt", 32'(gnt), 32'b0100);
        check("wr_busy1", 32'(busy), 32'h1);
        check("wr_q0_pre", 32'(q0), 32'h00);
        wdata = 32'h88A5_FFFF;
        step();
        check("wr_q0", 32'(q0), 32'hA5);
        check("wr_q1", 32'(q1), 32'h5A);
        check("wr_cnt", 32'(wr_count), 32'd1);
        check("wr_gnt_off", 32'(gnt), 32'h0);
        check("wr_busy2", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("wr_busy3", 32'(busy), 32'h1);
        step();
        check("wr_idle", 32'(busy), 32'h0);
        check("wr_q0_hold", 32'(q0), 32'hA5);

        // Fairness: all requesting, held through reset
        reset = 1'b1;
        req   = 4'b1111;
        wdata = 32'h4342_4140;
        step();
        check("fair_rst_cnt", 32'(wr_count), 32'h0);
        check("fair_rst_q0", 32'(q0), 32'h00);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("fair_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            check("fair_owner", 32'(owner), 32'(k % 4));
            step();
            check("fair_q0", 32'(q0), 32'(8'h40 + (k % 4)));
            check("fair_cnt", 32'(wr_count), 32'(k + 1));
            step();
            check("fair_hold_gnt", 32'(gnt), 32'h0);
            step();
            check("fair_idle", 32'(busy), 32'h0);
        end
        req = 4'b0000;

        // Reset mid-HOLD after writing 8'h3C by requester 2
        req   = 4'b0100;
        wdata = 32'h003C_0000;
        step();
        check("rh_gnt", 32'(gnt), 32'b0100);
        step();
        check("rh_q0", 32'(q0), 32'h3C);
        check("rh_cnt", 32'(wr_count), 32'd6);
        req = 4'b0000;
        step();
        reset = 1'b1;
        step();
        check("rh_q0_rst", 32'(q0), 32'h00);
        check("rh_q1_rst", 32'(q1), 32'hFF);
        check("rh_busy", 32'(busy), 32'h0);
        check("rh_cnt_rst", 32'(wr_count), 32'h0);
        check("rh_owner", 32'(owner), 32'h0);
        reset = 1'b0;

        // Reset mid-GRANT discards the pending write
        req   = 4'b0001;
        wdata = 32'h0000_0099;
        step();
        check("rg_gnt", 32'(gnt), 32'b0001);
        reset = 1'b1;
        step();
        check("rg_q0", 32'(q0), 32'h00);
        check("rg_cnt", 32'(wr_count), 32'h0);
        check("rg_gnt_rst", 32'(gnt), 32'h0);
        reset = 1'b0;
        req   = 4'b0000;
        step();
        check("rg_q0_after", 32'(q0), 32'h00);
        check("rg_busy_after", 32'(busy), 32'h0);

        armed = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule
